// File: rtl/eth_mem_arbiter_if.sv
// Bus bundle for the two-master shared-memory arbiter: both master ports,
// the shared memory port and the current grant vector.
interface eth_mem_arbiter_if;
    logic [31:0] m0_address;
    logic [31:0] m0_writedata;
    logic [3:0]  m0_byteenable;
    logic        m0_read;
    logic        m0_write;
    logic [31:0] m0_readdata;
    logic        m0_waitrequest_n;

    logic [31:0] m1_address;
    logic [31:0] m1_writedata;
    logic [3:0]  m1_byteenable;
    logic        m1_read;
    logic        m1_write;
    logic [31:0] m1_readdata;
    logic        m1_waitrequest_n;

    logic [31:0] s_address;
    logic [31:0] s_writedata;
    logic [3:0]  s_byteenable;
    logic        s_read;
    logic        s_write;
    logic [31:0] s_readdata;
    logic        s_waitrequest_n;

    logic [1:0]  grant;

    // Arbiter side
    modport slave (
        input  m0_address, m0_writedata, m0_byteenable, m0_read, m0_write,
        output m0_readdata, m0_waitrequest_n,
        input  m1_address, m1_writedata, m1_byteenable, m1_read, m1_write,
        output m1_readdata, m1_waitrequest_n,
        output s_address, s_writedata, s_byteenable, s_read, s_write,
        input  s_readdata, s_waitrequest_n,
        output grant
    );

    // Requester / memory side
    modport master (
        output m0_address, m0_writedata, m0_byteenable, m0_read, m0_write,
        input  m0_readdata, m0_waitrequest_n,
        output m1_address, m1_writedata, m1_byteenable, m1_read, m1_write,
        input  m1_readdata, m1_waitrequest_n,
        input  s_address, s_writedata, s_byteenable, s_read, s_write,
        output s_readdata, s_waitrequest_n,
        input  grant
    );
endinterface

// File: rtl/eth_mem_arbiter.sv
// Two-master arbiter (MAC DMA = m0, CPU = m1) for one shared memory port.
// Registered arbitration, combinational data path, bounded hold under contention.
module eth_mem_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              reset,
    eth_mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [4:0] HOLD_MAX = 5'(MAX_HOLD);

    state_t     r_state;
    logic [3:0] r_hold_cnt;
    logic       r_last_owner;

    state_t     w_state_nxt;
    logic [3:0] w_hold_nxt;
    logic       w_last_nxt;

    logic       w_req0;
    logic       w_req1;
    logic [4:0] w_hold_inc;
    logic [3:0] w_hold_sat;
    logic       w_switch_due;

    assign w_req0       = bus.m0_read | bus.m0_write;
    assign w_req1       = bus.m1_read | bus.m1_write;
    assign w_hold_inc   = {1'b0, r_hold_cnt} + 5'd1;
    assign w_hold_sat   = (w_hold_inc > HOLD_MAX) ? r_hold_cnt : w_hold_inc[3:0];
    assign w_switch_due = (w_hold_inc >= HOLD_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_hold_cnt   <= '0;
            r_last_owner <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_hold_cnt   <= w_hold_nxt;
            r_last_owner <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        w_last_nxt  = r_last_owner;
        case (r_state)
            IDLE: begin
                w_hold_nxt = '0;
                // On a tie the master that did not own last wins
                if (w_req0 && (!w_req1 || r_last_owner))
                    w_state_nxt = OWN0;
                else if (w_req1)
                    w_state_nxt = OWN1;
            end
            OWN0: begin
                if (!w_req0) begin
                    w_hold_nxt  = '0;
                    w_state_nxt = w_req1 ? OWN1 : IDLE;
                end else if (bus.s_waitrequest_n) begin
                    if (w_req1 && w_switch_due) begin
                        w_hold_nxt  = '0;
                        w_state_nxt = OWN1;
                    end else begin
                        w_hold_nxt  = w_hold_sat;
                    end
                end
            end
            OWN1: begin
                if (!w_req1) begin
                    w_hold_nxt  = '0;
                    w_state_nxt = w_req0 ? OWN0 : IDLE;
                end else if (bus.s_waitrequest_n) begin
                    if (w_req0 && w_switch_due) begin
                        w_hold_nxt  = '0;
                        w_state_nxt = OWN0;
                    end else begin
                        w_hold_nxt  = w_hold_sat;
                    end
                end
            end
            default: begin
                w_hold_nxt  = '0;
                w_state_nxt = IDLE;
            end
        endcase
        if (w_state_nxt == OWN0)
            w_last_nxt = 1'b0;
        else if (w_state_nxt == OWN1)
            w_last_nxt = 1'b1;
    end

    assign bus.m0_readdata = bus.s_readdata;
    assign bus.m1_readdata = bus.s_readdata;

    always_comb begin
        bus.s_address        = '0;
        bus.s_writedata      = '0;
        bus.s_byteenable     = '0;
        bus.s_read           = 1'b0;
        bus.s_write          = 1'b0;
        bus.m0_waitrequest_n = 1'b0;
        bus.m1_waitrequest_n = 1'b0;
        bus.grant            = 2'b00;
        case (r_state)
            OWN0: begin
                bus.grant            = 2'b01;
                bus.s_address        = bus.m0_address;
                bus.s_writedata      = bus.m0_writedata;
                bus.s_byteenable     = bus.m0_byteenable;
                bus.s_write          = bus.m0_write;
                bus.s_read           = bus.m0_read & ~bus.m0_write;
                bus.m0_waitrequest_n = bus.s_waitrequest_n & w_req0;
            end
            OWN1: begin
                bus.grant            = 2'b10;
                bus.s_address        = bus.m1_address;
                bus.s_writedata      = bus.m1_writedata;
                bus.s_byteenable     = bus.m1_byteenable;
                bus.s_write          = bus.m1_write;
                bus.s_read           = bus.m1_read & ~bus.m1_write;
                bus.m1_waitrequest_n = bus.s_waitrequest_n & w_req1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_eth_mem_arbiter.sv
// Directed bench for eth_mem_arbiter: a per-cycle vector table plus
// hand-written sequences for alternation, saturation and async reset.
module tb_eth_mem_arbiter;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    eth_mem_arbiter_if bus ();

    eth_mem_arbiter #(.MAX_HOLD(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        m0r, m0w, m1r, m1w, swn;
        logic [1:0]  grant;
        logic        sr, sw, w0, w1;
        logic [31:0] saddr, swdata;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input logic m0r, input logic m0w, input logic m1r,
                                input logic m1w, input logic swn, input logic [1:0] g,
                                input logic sr, input logic sw, input logic w0,
                                input logic w1, input logic [31:0] sa, input logic [31:0] sd);
        vec_t v;
        v.m0r = m0r; v.m0w = m0w; v.m1r = m1r; v.m1w = m1w; v.swn = swn;
        v.grant = g; v.sr = sr; v.sw = sw; v.w0 = w0; v.w1 = w1;
        v.saddr = sa; v.swdata = sd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic m0r, input logic m0w, input logic m1r,
                           input logic m1w, input logic swn);
        bus.m0_read = m0r; bus.m0_write = m0w;
        bus.m1_read = m1r; bus.m1_write = m1w;
        bus.s_waitrequest_n = swn;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        set_req(0, 0, 0, 0, 0);
        advance();
        reset = 1'b0;
    endtask

    localparam logic [31:0] A0 = 32'h0000_0100;
    localparam logic [31:0] A1 = 32'h0000_0200;
    localparam logic [31:0] D0 = 32'hDEAD_BEEF;
    localparam logic [31:0] D1 = 32'h1234_5678;

    initial begin
        logic [1:0] eg;
        int         n_comp;
        n_checks = 0;
        n_fail   = 0;

        bus.m0_address = A0; bus.m0_writedata = D0; bus.m0_byteenable = 4'hF;
        bus.m1_address = A1; bus.m1_writedata = D1; bus.m1_byteenable = 4'h3;
        bus.s_readdata = 32'hCAFE_F00D;
        set_req(1, 0, 0, 1, 1);
        reset = 1'b1;

        // Outputs held at zero during reset even with requests present
        @(negedge clk);
        chk("rst grant", 32'(bus.grant), 0);
        chk("rst s_read", 32'(bus.s_read), 0);
        chk("rst s_write", 32'(bus.s_write), 0);
        chk("rst m0_wrn", 32'(bus.m0_waitrequest_n), 0);
        chk("rst s_address", bus.s_address, 0);
        chk("rst readdata", bus.m0_readdata, 32'hCAFE_F00D);
        chk("rst hold_cnt", 32'(dut.r_hold_cnt), 0);
        advance();
        reset = 1'b0;

        //               m0r m0w m1r m1w swn  grant  sr sw w0 w1 saddr swdata
        vecs[0]  = mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0,  0);
        vecs[1]  = mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0,  0);
        vecs[2]  = mk(1, 0, 0, 0, 0, 2'b01, 1, 0, 0, 0, A0, D0);
        vecs[3]  = mk(1, 0, 0, 0, 0, 2'b01, 1, 0, 0, 0, A0, D0);
        vecs[4]  = mk(1, 0, 0, 0, 1, 2'b01, 1, 0, 1, 0, A0, D0);
        vecs[5]  = mk(0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, A0, D0);
        vecs[6]  = mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0,  0);
        vecs[7]  = mk(1, 1, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0,  0);
        vecs[8]  = mk(1, 1, 0, 0, 1, 2'b01, 0, 1, 1, 0, A0, D0);
        vecs[9]  = mk(0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, A0, D0);
        vecs[10] = mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0,  0);
        vecs[11] = mk(0, 0, 0, 1, 1, 2'b00, 0, 0, 0, 0, 0,  0);
        vecs[12] = mk(0, 0, 0, 1, 1, 2'b10, 0, 1, 0, 1, A1, D1);
        vecs[13] = mk(1, 0, 0, 1, 1, 2'b10, 0, 1, 0, 1, A1, D1);
        vecs[14] = mk(1, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, A1, D1);
        vecs[15] = mk(1, 0, 0, 0, 0, 2'b01, 1, 0, 0, 0, A0, D0);
        vecs[16] = mk(0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, A0, D0);
        vecs[17] = mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0,  0);

        for (int i = 0; i < 18; i++) begin
            set_req(vecs[i].m0r, vecs[i].m0w, vecs[i].m1r, vecs[i].m1w, vecs[i].swn);
            bus.s_readdata = 32'h1000 + 32'(i);
            @(negedge clk);
            chk($sformatf("v%0d grant", i), 32'(bus.grant), 32'(vecs[i].grant));
            chk($sformatf("v%0d s_read", i), 32'(bus.s_read), 32'(vecs[i].sr));
            chk($sformatf("v%0d s_write", i), 32'(bus.s_write), 32'(vecs[i].sw));
            chk($sformatf("v%0d m0_wrn", i), 32'(bus.m0_waitrequest_n), 32'(vecs[i].w0));
            chk($sformatf("v%0d m1_wrn", i), 32'(bus.m1_waitrequest_n), 32'(vecs[i].w1));
            chk($sformatf("v%0d s_address", i), bus.s_address, vecs[i].saddr);
            chk($sformatf("v%0d s_writedata", i), bus.s_writedata, vecs[i].swdata);
            chk($sformatf("v%0d m0_readdata", i), bus.m0_readdata, 32'h1000 + 32'(i));
            chk($sformatf("v%0d m1_readdata", i), bus.m1_readdata, 32'h1000 + 32'(i));
            advance();
        end

        // Continuous contention: four completions per owner, no idle bubble
        reset_pulse();
        set_req(0, 1, 0, 1, 1);
        @(negedge clk);
        chk("alt idle grant", 32'(bus.grant), 0);
        advance();
        for (int k = 0; k < 16; k++) begin
            eg = (((k / 4) % 2) == 0) ? 2'b01 : 2'b10;
            @(negedge clk);
            chk($sformatf("alt%0d grant", k), 32'(bus.grant), 32'(eg));
            chk($sformatf("alt%0d s_write", k), 32'(bus.s_write), 1);
            chk($sformatf("alt%0d m0_wrn", k), 32'(bus.m0_waitrequest_n), 32'(eg[0]));
            chk($sformatf("alt%0d m1_wrn", k), 32'(bus.m1_waitrequest_n), 32'(eg[1]));
            chk($sformatf("alt%0d s_byteenable", k), 32'(bus.s_byteenable),
                eg[0] ? 32'hF : 32'h3);
            advance();
        end

        // Lone master keeps ownership, hold counter saturates
        reset_pulse();
        set_req(0, 0, 0, 1, 1);
        advance();
        n_comp = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("solo%0d grant", k), 32'(bus.grant), 32'(2'b10));
            if (bus.m1_waitrequest_n === 1'b1) n_comp++;
            advance();
        end
        chk("solo completions", 32'(n_comp), 10);
        chk("solo hold_cnt", 32'(dut.r_hold_cnt), 4);
        set_req(0, 0, 0, 0, 0);
        advance();
        @(negedge clk);
        chk("solo release grant", 32'(bus.grant), 0);
        chk("solo release s_write", 32'(bus.s_write), 0);
        advance();

        // Async reset during a stalled m1 write, then m0 wins the restart tie
        reset_pulse();
        set_req(0, 0, 0, 1, 0);
        advance();
        @(negedge clk);
        chk("stall grant", 32'(bus.grant), 32'(2'b10));
        chk("stall s_write", 32'(bus.s_write), 1);
        advance();
        set_req(0, 1, 0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("stall%0d grant", k), 32'(bus.grant), 32'(2'b10));
            chk($sformatf("stall%0d m0_wrn", k), 32'(bus.m0_waitrequest_n), 0);
            chk($sformatf("stall%0d s_address", k), bus.s_address, A1);
            advance();
        end
        reset = 1'b1;
        #2;
        chk("async rst s_write", 32'(bus.s_write), 0);
        chk("async rst grant", 32'(bus.grant), 0);
        advance();
        reset = 1'b0;
        @(negedge clk);
        chk("restart idle grant", 32'(bus.grant), 0);
        chk("restart idle s_write", 32'(bus.s_write), 0);
        advance();
        @(negedge clk);
        chk("restart grant", 32'(bus.grant), 32'(2'b01));
        chk("restart s_address", bus.s_address, A0);
        chk("restart s_write", 32'(bus.s_write), 1);
        advance();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_mem_arbiter.md
ETH_MEM_ARBITER -- requirements
Module: eth_mem_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, 4, max consecutive completed transfers granted to one master while the other is requesting (legal 1..15).
REQ-002 clk  in  1  system clock; all logic rising-edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 m0_address/m0_writedata  in  32 each  master 0 (MAC DMA) address, write data.
REQ-005 m0_byteenable  in  4  master 0 byte lanes.
REQ-006 m0_read/m0_write  in  1 each  master 0 read, write requests.
REQ-007 m0_readdata  out  32  read data to master 0.
REQ-008 m0_waitrequest_n  out  1  transfer-accepted strobe to master 0.
REQ-009 m1_* ports  as REQ-004..REQ-008  master 1 (CPU/host).
REQ-010 s_address/s_writedata  out  32 each; s_byteenable  out  4; s_read/s_write  out  1 each  shared memory port.
REQ-011 s_readdata  in  32; s_waitrequest_n  in  1  memory port response; accepted when high.
REQ-012 grant  out  2  one-hot current owner ({m1,m0}), 2'b00 when idle.

Function
REQ-013 Master request = read | write; if both asserted, write wins (forwarded read = read & ~write).
REQ-014 FSM states IDLE, OWN0, OWN1; grant = 01 in OWN0, 10 in OWN1, 00 in IDLE.
REQ-015 IDLE: one requester -> own it next cycle; both -> own the master not in last_owner; none -> stay.
REQ-016 Grant latency: request seen in IDLE produces s_read/s_write no earlier than next cycle (one registered arbitration cycle).
REQ-017 OWNx: s_address, s_writedata, s_byteenable, s_read, s_write driven combinationally from master x; other master's request ignored.
REQ-018 OWNx: mx_waitrequest_n = s_waitrequest_n & (mx_read | mx_write); non-owner waitrequest_n = 0.
REQ-019 IDLE: s_read = s_write = 0, all mX_waitrequest_n = 0, s_address/s_writedata/s_byteenable = 0.
REQ-020 s_readdata broadcast to m0_readdata and m1_readdata unregistered.
REQ-021 Completion = owner request & s_waitrequest_n in OWNx; hold_cnt (4 bits) increments on completion, saturating at MAX_HOLD.
REQ-022 On completion: if other master requesting and hold_cnt+1 >= MAX_HOLD -> switch to other owner next cycle, hold_cnt = 0; else stay.
REQ-023 OWNx with owner request low: other requesting -> switch to other; else -> IDLE; hold_cnt = 0.
REQ-024 Ownership never changes while owner request is high and s_waitrequest_n is low (no transfer abort).
REQ-025 last_owner updated on every entry to OWN0/OWN1.
REQ-026 Other master idle: owner keeps grant indefinitely, hold_cnt saturates, no forced switch.
REQ-027 Switch OWN0<->OWN1 occurs directly without IDLE bubble; new owner's signals driven the cycle after the switch decision.

Reset
REQ-028 Reset asserted: state = IDLE, grant = 00, hold_cnt = 0, last_owner = m1 (so m0 wins first tie), all outputs 0 except readdata passthrough.
REQ-029 Reset mid-transfer: s_read/s_write drop asynchronously; no completion reported; arbitration restarts from IDLE after deassertion.

Verification
REQ-030 Only m0 reads 0x100, s_waitrequest_n high after 2 stall cycles -> grant 01 one cycle after request, m0_waitrequest_n high exactly one cycle, m0_readdata = s_readdata.
REQ-031 m0, m1 both write from IDLE after reset -> m0 owns first; with MAX_HOLD=4 and continuous requests, grant alternates after every 4 completions, no idle cycle between owners.
REQ-032 m1 alone issues 10 back-to-back writes -> grant stays 10, 10 completions, hold_cnt saturates at 4, no switch.
REQ-033 m0 asserts read and write together with writedata 0xDEADBEEF -> s_write = 1, s_read = 0, s_writedata = 0xDEADBEEF.
REQ-034 Reset asserted while m1 write stalled (s_waitrequest_n low) -> s_write, grant to 0 same cycle; after release, pending m0 and m1 requests -> m0 granted first.
REQ-035 Owner m0 drops request while m1 idle -> IDLE next cycle, grant 00, s_read/s_write 0.
